// File: rtl/regfile_wb_sched_if.sv
// Producer-to-register-file write-back bus: per-producer result requests in,
// registered write-port signals out.
interface regfile_wb_sched_if #(
  parameter int NREQ      = 3,
  parameter int REG_WIDTH = 64
);
  // Handshake: a transfer on producer i happens in a cycle where
  // req_valid[i] && req_ready[i]. A producer that is not yet ready must keep
  // valid, rd and data stable until it is accepted.
  logic [NREQ-1:0]                req_valid;
  logic [NREQ-1:0]                req_ready;
  logic [NREQ-1:0][4:0]           req_rd;
  logic [NREQ-1:0][REG_WIDTH-1:0] req_data;
  logic                           wb_reg_write;
  logic [4:0]                     wb_rd;
  logic [REG_WIDTH-1:0]           wb_data;

  modport master (
    output req_valid, req_rd, req_data,
    input  req_ready, wb_reg_write, wb_rd, wb_data
  );

  modport slave (
    input  req_valid, req_rd, req_data,
    output req_ready, wb_reg_write, wb_rd, wb_data
  );
endinterface

// File: rtl/regfile_wb_sched.sv
// Round-robin write-back scheduler for the single register-file write port,
// with a pending-write scoreboard for RAW hazard checks.
module regfile_wb_sched #(
  parameter int NREQ      = 3,
  parameter int REG_WIDTH = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  regfile_wb_sched_if.slave   bus,
  input  logic                issue_valid,
  input  logic [4:0]          issue_rd,
  output logic [31:0]         busy,
  input  logic                finish,
  output logic                idle
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]        ptr_q, ptr_d;
  logic [NREQ-1:0]      elig;
  logic [NREQ-1:0]      x0_ok;
  logic                 grant_any;
  logic [PW-1:0]        win;
  logic [PW-1:0]        idx;
  logic [4:0]           win_rd;
  logic                 wb_we_q;
  logic [4:0]           wb_rd_q;
  logic [REG_WIDTH-1:0] wb_data_q;
  logic [31:0]          busy_q, busy_d;

  // Nothing is accepted during reset or while finish is held, since an
  // accepted result would be lost.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      elig[i]  = rst_n && !finish && bus.req_valid[i] && (bus.req_rd[i] != 5'd0);
      x0_ok[i] = rst_n && !finish && bus.req_valid[i] && (bus.req_rd[i] == 5'd0);
    end
  end

  always_comb begin
    grant_any = 1'b0;
    win       = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (int'(ptr_q) + k >= NREQ) idx = PW'(int'(ptr_q) + k - NREQ);
      else                         idx = PW'(int'(ptr_q) + k);
      if (!grant_any && elig[idx]) begin
        grant_any = 1'b1;
        win       = idx;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      bus.req_ready[i] = x0_ok[i] || (grant_any && (win == PW'(i)));
    end
  end

  assign win_rd = bus.req_rd[win];

  always_comb begin
    ptr_d = ptr_q;
    if (grant_any) ptr_d = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
  end

  // A new issue to the same rd wins over the clear: a newer producer is in flight.
  always_comb begin
    busy_d = busy_q;
    if (grant_any) busy_d[win_rd] = 1'b0;
    if (issue_valid && (issue_rd != 5'd0)) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      wb_we_q   <= 1'b0;
      wb_rd_q   <= 5'd0;
      wb_data_q <= '0;
      busy_q    <= 32'd0;
    end else begin
      ptr_q   <= ptr_d;
      wb_we_q <= grant_any;
      busy_q  <= busy_d;
      if (grant_any) begin
        wb_rd_q   <= win_rd;
        wb_data_q <= bus.req_data[win];
      end
    end
  end

  assign bus.wb_reg_write = wb_we_q;
  assign bus.wb_rd        = wb_rd_q;
  assign bus.wb_data      = wb_data_q;
  assign busy             = busy_q;
  assign idle             = (busy_q == 32'd0) && !wb_we_q;
endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: reset, round-robin order, x0 bypass,
// scoreboard set/clear, finish and asynchronous reset.
module tb_regfile_wb_sched;
  localparam int NREQ = 3;
  localparam int RW   = 64;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [31:0] busy;
  logic        finish;
  logic        idle;

  int errors = 0;
  int checks = 0;

  regfile_wb_sched_if #(.NREQ(NREQ), .REG_WIDTH(RW)) bus ();

  regfile_wb_sched #(.NREQ(NREQ), .REG_WIDTH(RW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .busy        (busy),
    .finish      (finish),
    .idle        (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_rd[i]   = 5'd0;
      bus.req_data[i] = '0;
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    issue_valid = 1'b0;
    issue_rd    = 5'd0;
    finish      = 1'b0;
    clear_reqs();

    // Reset held with random inputs
    for (int c = 0; c < 3; c++) begin
      bus.req_valid = NREQ'($urandom_range(0, 7));
      for (int i = 0; i < NREQ; i++) begin
        bus.req_rd[i]   = 5'($urandom_range(0, 31));
        bus.req_data[i] = {$urandom(), $urandom()};
      end
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd    = 5'($urandom_range(0, 31));
      finish      = 1'($urandom_range(0, 1));
      tick();
      check("rst_we", 64'(bus.wb_reg_write), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_idle", 64'(idle), 64'd1);
      check("rst_ready", 64'(bus.req_ready), 64'd0);
    end

    rst_n       = 1'b1;
    issue_valid = 1'b0;
    finish      = 1'b0;
    clear_reqs();
    bus.req_valid[1] = 1'b1;
    bus.req_rd[1]    = 5'd5;
    bus.req_data[1]  = 64'hDEAD;
    #1;
    check("first_ready", 64'(bus.req_ready), 64'b010);
    tick();
    clear_reqs();
    check("first_we", 64'(bus.wb_reg_write), 64'd1);
    check("first_rd", 64'(bus.wb_rd), 64'd5);
    check("first_data", bus.wb_data, 64'hDEAD);

    // ptr is now 2; a grant on index 2 brings it back to 0
    bus.req_valid[2] = 1'b1;
    bus.req_rd[2]    = 5'd4;
    bus.req_data[2]  = 64'h44;
    #1;
    check("p2_ready", 64'(bus.req_ready), 64'b100);
    tick();
    clear_reqs();
    check("p2_rd", 64'(bus.wb_rd), 64'd4);
    check("p2_data", bus.wb_data, 64'h44);

    // Round-robin with all three valid
    bus.req_valid = 3'b111;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_rd[i]   = 5'(i + 1);
      bus.req_data[i] = 64'h100 + 64'(i);
    end
    for (int c = 0; c < 6; c++) begin
      #1;
      check("rr_ready", 64'(bus.req_ready), 64'(1 << (c % 3)));
      tick();
      check("rr_we", 64'(bus.wb_reg_write), 64'd1);
      check("rr_rd", 64'(bus.wb_rd), 64'((c % 3) + 1));
      check("rr_data", bus.wb_data, 64'h100 + 64'(c % 3));
    end
    clear_reqs();

    // x0 bypass alongside a real request
    bus.req_valid   = 3'b101;
    bus.req_rd[0]   = 5'd0;
    bus.req_data[0] = 64'hBAD;
    bus.req_rd[2]   = 5'd7;
    bus.req_data[2] = 64'h77;
    #1;
    check("x0_ready", 64'(bus.req_ready), 64'b101);
    tick();
    clear_reqs();
    check("x0_we", 64'(bus.wb_reg_write), 64'd1);
    check("x0_rd", 64'(bus.wb_rd), 64'd7);
    check("x0_data", bus.wb_data, 64'h77);
    tick();
    check("x0_nowrite", 64'(bus.wb_reg_write), 64'd0);
    check("x0_idle", 64'(idle), 64'd1);

    // Scoreboard set, then cleared by the grant
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    tick();
    issue_valid = 1'b0;
    check("sb_set", 64'(busy), 64'(32'h200));
    check("sb_not_idle", 64'(idle), 64'd0);
    tick();
    tick();
    check("sb_hold", 64'(busy), 64'(32'h200));
    bus.req_valid[1] = 1'b1;
    bus.req_rd[1]    = 5'd9;
    bus.req_data[1]  = 64'h99;
    #1;
    check("sb_ready", 64'(bus.req_ready), 64'b010);
    tick();
    clear_reqs();
    check("sb_clear", 64'(busy), 64'd0);
    check("sb_we", 64'(bus.wb_reg_write), 64'd1);
    check("sb_rd", 64'(bus.wb_rd), 64'd9);

    // Set and clear of the same rd at one edge: set wins (ptr is 2)
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    tick();
    check("sb2_set", 64'(busy), 64'(32'h200));
    bus.req_valid[2] = 1'b1;
    bus.req_rd[2]    = 5'd9;
    bus.req_data[2]  = 64'h999;
    #1;
    check("sb2_ready", 64'(bus.req_ready), 64'b100);
    tick();
    issue_valid = 1'b0;
    clear_reqs();
    check("sb2_keep", 64'(busy), 64'(32'h200));
    check("sb2_we", 64'(bus.wb_reg_write), 64'd1);

    // finish with two requests pending and one write in flight (ptr is 0)
    bus.req_valid   = 3'b011;
    bus.req_rd[0]   = 5'd10;
    bus.req_data[0] = 64'hA0;
    bus.req_rd[1]   = 5'd11;
    bus.req_data[1] = 64'hB1;
    #1;
    check("fin_pre_ready", 64'(bus.req_ready), 64'b001);
    tick();
    bus.req_rd[0]   = 5'd12;
    bus.req_data[0] = 64'hC2;
    bus.req_valid[2] = 1'b1;
    bus.req_rd[2]    = 5'd0;
    finish = 1'b1;
    #1;
    check("fin_ready", 64'(bus.req_ready), 64'd0);
    check("fin_trail_we", 64'(bus.wb_reg_write), 64'd1);
    check("fin_trail_rd", 64'(bus.wb_rd), 64'd10);
    issue_valid = 1'b1;
    issue_rd    = 5'd20;
    tick();
    issue_valid = 1'b0;
    check("fin_we_off", 64'(bus.wb_reg_write), 64'd0);
    check("fin_sb_set", 64'(busy), 64'(32'h0010_0200));
    check("fin_hold_rd", 64'(bus.wb_rd), 64'd10);
    tick();
    check("fin_ready2", 64'(bus.req_ready), 64'd0);
    check("fin_we_off2", 64'(bus.wb_reg_write), 64'd0);

    // Drain the scoreboard after finish drops (ptr is 1)
    finish = 1'b0;
    clear_reqs();
    bus.req_valid[0] = 1'b1;
    bus.req_rd[0]    = 5'd9;
    #1;
    check("drain_ready", 64'(bus.req_ready), 64'b001);
    tick();
    check("drain_busy1", 64'(busy), 64'(32'h0010_0000));
    bus.req_rd[0] = 5'd20;
    tick();
    clear_reqs();
    check("drain_busy2", 64'(busy), 64'd0);
    check("drain_not_idle", 64'(idle), 64'd0);
    tick();
    check("drain_idle", 64'(idle), 64'd1);

    // Asynchronous reset in the middle of a burst (ptr is 1)
    bus.req_valid = 3'b111;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_rd[i]   = 5'(i + 1);
      bus.req_data[i] = 64'h200 + 64'(i);
    end
    issue_valid = 1'b1;
    issue_rd    = 5'd15;
    tick();
    issue_valid = 1'b0;
    check("ar_pre_rd", 64'(bus.wb_rd), 64'd2);
    check("ar_pre_busy", 64'(busy), 64'(32'h8000));
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_we", 64'(bus.wb_reg_write), 64'd0);
    check("ar_rd", 64'(bus.wb_rd), 64'd0);
    check("ar_data", bus.wb_data, 64'd0);
    check("ar_busy", 64'(busy), 64'd0);
    check("ar_idle", 64'(idle), 64'd1);
    check("ar_ready", 64'(bus.req_ready), 64'd0);
    #1;
    rst_n = 1'b1;
    #1;
    check("ar_ptr0", 64'(bus.req_ready), 64'b001);
    tick();
    clear_reqs();
    check("ar_post_rd", 64'(bus.wb_rd), 64'd1);
    check("ar_post_data", bus.wb_data, 64'h200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_wb_sched.md
# regfile_wb_sched

Write-back scheduler for the 32×64 integer register file. Several producers (ALU, load unit, mul/div) compete for the file's single write port. The block grants one producer per cycle by round-robin and registers the winner onto the port's `reg_write`/`rd`/`reg_data` inputs. It also keeps a pending-write scoreboard that issue logic uses for RAW hazard checks.

## Interface
- `NREQ`, default 3: number of write-back requesters. Index 0 = ALU, 1 = load, 2 = mul/div.
- `REG_WIDTH`, default 64: register data width.

Ports:
- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req_valid`  in  NREQ: producer i has a result.
- `req_ready`  out  NREQ: producer i's result is accepted this cycle.
- `req_rd`  in  NREQ×5: destination register per producer.
- `req_data`  in  NREQ×REG_WIDTH: result data per producer.
- `wb_reg_write`  out  1: drives the register file write enable.
- `wb_rd`  out  5: drives the register file `rd`.
- `wb_data`  out  REG_WIDTH: drives the register file `reg_data`.
- `issue_valid`  in  1: an instruction writing `issue_rd` is issued this cycle.
- `issue_rd`  in  5: destination register of the issuing instruction.
- `busy`  out  32: bit r set means a write to xr is in flight.
- `finish`  in  1: simulation end request.
- `idle`  out  1: no write pending or in flight.

## Operation
- **Transfer rule:** a transfer on producer i occurs when `req_valid[i] && req_ready[i]`. `req_ready` is combinational from `req_valid`, `req_rd`, the round-robin pointer and `finish`.
- **x0 results:** a valid request with `req_rd == 0` is ready in the same cycle.
  - It does not take part in arbitration and produces no write.
  - Any number of x0 requests can complete in one cycle.
- **Arbitration:**
  - Eligible set: valid requests with `req_rd != 0`.
  - Search order starts at pointer `ptr` (0..NREQ-1) and wraps modulo NREQ. The first eligible index wins, and only the winner sees `req_ready` high.
  - On a grant, `ptr` becomes (winner+1) mod NREQ. With no grant, `ptr` holds.
- **Write-port register:** on a grant, the next edge loads `wb_reg_write=1`, `wb_rd=req_rd[w]`, `wb_data=req_data[w]`. With no grant, the next edge loads `wb_reg_write=0`; `wb_rd` and `wb_data` hold their values.
- **Scoreboard:**
  - Set: `busy[issue_rd]` is set at the edge where `issue_valid && issue_rd != 0`.
  - Clear: `busy[rd]` is cleared at the edge where a grant for that `rd` is captured, i.e. the same edge that loads `wb_reg_write=1`.
  - Same `rd` set and cleared at the same edge: set wins, because a newer producer is in flight.
  - `busy[0]` is always 0. `issue_valid` with rd 0 is ignored.
- **finish:** while `finish=1`, all `req_ready` are 0, including for x0 requests. No grants occur and `ptr` holds. An in-flight `wb_reg_write` still completes. The scoreboard still accepts sets.
- **idle:** `idle = (busy == 0) && !wb_reg_write`, combinational.
- **Reset values:** `wb_reg_write=0`, `wb_rd=0`, `wb_data=0`, `busy=0`, `ptr=0`. Hence `idle=1`.
- **Reset asserted mid-operation:** all of the above return to their reset values immediately (asynchronous). A write captured but not yet presented is dropped.

## Timing
- Grant to register-file write: 1 cycle. The grant is at cycle N (combinational `req_ready`). `wb_*` is valid during cycle N+1, and the register file commits at the edge ending N+1.
- Sustained throughput: one write per cycle. Back-to-back grants keep `wb_reg_write` high continuously.
- A losing producer must hold `valid`, `rd` and `data` stable until it is granted. Its `req_ready` stays 0 meanwhile.
- Worst-case wait with NREQ requesters continuously valid: NREQ-1 cycles.
- `busy` is visible one cycle after `issue_valid`. The clear is visible in the cycle `wb_reg_write` is high, so issue logic must forward `wb_data` or accept a 1-cycle bubble.

## Test plan
- **Reset:** hold `rst_n=0` for 3 cycles with random inputs. Expect `wb_reg_write=0`, `busy=0`, `idle=1`, `req_ready=0`. Deassert and drive a single valid on index 1 (rd=5, data=0xDEAD). Expect `req_ready=3'b010` the same cycle, and the next cycle `wb_reg_write=1`, `wb_rd=5`, `wb_data=0xDEAD`.
- **Round-robin fairness:** hold all three valid for 6 cycles (rd=1/2/3) with `ptr=0`. Expect grant order 0,1,2,0,1,2. Each `wb_rd` appears exactly one cycle after its grant.
- **x0 bypass:** index 0 valid with rd=0 and index 2 valid with rd=7 in the same cycle. Expect `req_ready=3'b101`, then one write with `wb_rd=7` and no write for rd 0.
- **Scoreboard:**
  - `issue_valid`, rd=9 at cycle 0: expect `busy[9]=1` at cycle 1.
  - Grant rd=9 at cycle 4: expect `busy[9]=0` and `wb_reg_write=1` at cycle 5.
  - Repeat with a new `issue_valid` rd=9 on the grant cycle: expect `busy[9]` to remain 1.
- **finish:** assert `finish` with two requests pending. Expect `req_ready=0` and at most one trailing `wb_reg_write` pulse. Once the scoreboard drains, expect `idle=1`.
- **Async reset mid-burst:** pulse `rst_n` low between clock edges during a sustained burst. Expect all outputs at reset values without waiting for an edge, and `ptr` restarting at index 0.
